// File: rtl/acct_filter.sv
// Access-control enforcement stage: forwards one request at a time when the requester's privilege is permitted.
// Optional violation log is built when ACCT_FILTER_LOG_EN is defined; otherwise the log outputs are tied to 0.
module acct_filter #(
  parameter int NB_PERIPHERALS = 9,
  parameter int IDX_W          = (NB_PERIPHERALS > 1) ? $clog2(NB_PERIPHERALS) : 1,
  parameter int AW             = 64,
  parameter int DW             = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [4*NB_PERIPHERALS-1:0] acc_ctrl_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AW-1:0]               req_addr_i,
  input  logic                        req_we_i,
  input  logic [DW-1:0]               req_wdata_i,
  input  logic [1:0]                  req_priv_i,
  input  logic [IDX_W-1:0]            req_periph_i,
  output logic                        dn_valid_o,
  input  logic                        dn_ready_i,
  output logic [AW-1:0]               dn_addr_o,
  output logic                        dn_we_o,
  output logic [DW-1:0]               dn_wdata_o,
  input  logic                        dn_rvalid_i,
  input  logic [DW-1:0]               dn_rdata_i,
  output logic                        rsp_valid_o,
  output logic [DW-1:0]               rsp_rdata_o,
  output logic                        rsp_err_o,
  input  logic                        viol_clr_i,
  output logic [15:0]                 viol_cnt_o,
  output logic [AW-1:0]               viol_addr_o,
  output logic [1:0]                  viol_priv_o,
  output logic                        viol_irq_o
);

  // state | meaning
  // IDLE  | ready for a new request
  // CHECK | permission lookup on the latched request
  // FWD   | presenting request downstream
  // WAIT  | waiting for downstream response
  // RESP  | one-cycle good response upstream
  // ERR   | one-cycle error response, violation logged
  typedef enum logic [2:0] {IDLE, CHECK, FWD, WAIT, RESP, ERR} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic              we_q;
  logic [DW-1:0]     wdata_q;
  logic [1:0]        priv_q;
  logic [IDX_W-1:0]  periph_q;
  logic [DW-1:0]     rdata_q;
  logic [3:0]        nibble;
  logic              allowed;
  logic              unused_nib2;

  // Out-of-range indices match no nibble and therefore read as all-deny.
  always_comb begin
    nibble = 4'h0;
    for (int p = 0; p < NB_PERIPHERALS; p++) begin
      if (periph_q == IDX_W'(p)) nibble = acc_ctrl_i[4*p +: 4];
    end
  end

  assign unused_nib2 = nibble[2];
  assign allowed = ((priv_q == 2'b11) & nibble[3]) |
                   ((priv_q == 2'b01) & nibble[1]) |
                   ((priv_q == 2'b00) & nibble[0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = CHECK;
      CHECK:   state_d = allowed ? FWD : ERR;
      FWD:     if (dn_ready_i) state_d = dn_rvalid_i ? RESP : WAIT;
      WAIT:    if (dn_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      priv_q   <= 2'b00;
      periph_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        addr_q   <= req_addr_i;
        we_q     <= req_we_i;
        wdata_q  <= req_wdata_i;
        priv_q   <= req_priv_i;
        periph_q <= req_periph_i;
      end
      if ((state_q == FWD && dn_ready_i && dn_rvalid_i) || (state_q == WAIT && dn_rvalid_i))
        rdata_q <= dn_rdata_i;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign dn_valid_o  = (state_q == FWD);
  assign dn_addr_o   = addr_q;
  assign dn_we_o     = we_q;
  assign dn_wdata_o  = wdata_q;
  assign rsp_valid_o = (state_q == RESP) || (state_q == ERR);
  assign rsp_err_o   = (state_q == ERR);
  assign rsp_rdata_o = (state_q == RESP && !we_q) ? rdata_q : '0;

`ifdef ACCT_FILTER_LOG_EN
  logic [15:0]   viol_cnt_q, viol_cnt_d;
  logic [AW-1:0] viol_addr_q, viol_addr_d;
  logic [1:0]    viol_priv_q, viol_priv_d;

  // A clear coincident with a violation restarts the log with that violation.
  always_comb begin
    viol_cnt_d  = viol_cnt_q;
    viol_addr_d = viol_addr_q;
    viol_priv_d = viol_priv_q;
    if (viol_clr_i) begin
      viol_cnt_d  = '0;
      viol_addr_d = '0;
      viol_priv_d = 2'b00;
    end
    if (state_q == ERR) begin
      if (viol_clr_i || viol_cnt_q == 16'h0000) begin
        viol_addr_d = addr_q;
        viol_priv_d = priv_q;
      end
      if (viol_clr_i)                    viol_cnt_d = 16'h0001;
      else if (viol_cnt_q != 16'hFFFF)   viol_cnt_d = viol_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_cnt_q  <= '0;
      viol_addr_q <= '0;
      viol_priv_q <= 2'b00;
    end else begin
      viol_cnt_q  <= viol_cnt_d;
      viol_addr_q <= viol_addr_d;
      viol_priv_q <= viol_priv_d;
    end
  end

  assign viol_cnt_o  = viol_cnt_q;
  assign viol_addr_o = viol_addr_q;
  assign viol_priv_o = viol_priv_q;
  assign viol_irq_o  = (viol_cnt_q != 16'h0000);
`else
  logic unused_clr;
  assign unused_clr  = viol_clr_i;
  assign viol_cnt_o  = '0;
  assign viol_addr_o = '0;
  assign viol_priv_o = 2'b00;
  assign viol_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_acct_filter.sv
// Directed self-checking bench for acct_filter; log expectations follow ACCT_FILTER_LOG_EN.
module tb_acct_filter;
`ifdef ACCT_FILTER_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [35:0] acc_ctrl;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_priv;
  logic [3:0]  req_periph;
  logic        dn_valid, dn_ready, dn_we, dn_rvalid;
  logic [63:0] dn_addr;
  logic [31:0] dn_wdata, dn_rdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        viol_clr, viol_irq;
  logic [15:0] viol_cnt;
  logic [63:0] viol_addr;
  logic [1:0]  viol_priv;

  int errors = 0;
  int checks = 0;

  acct_filter #(.NB_PERIPHERALS(9)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .acc_ctrl_i(acc_ctrl),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_priv_i(req_priv),
    .req_periph_i(req_periph), .dn_valid_o(dn_valid), .dn_ready_i(dn_ready),
    .dn_addr_o(dn_addr), .dn_we_o(dn_we), .dn_wdata_o(dn_wdata),
    .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .viol_clr_i(viol_clr),
    .viol_cnt_o(viol_cnt), .viol_addr_o(viol_addr), .viol_priv_o(viol_priv),
    .viol_irq_o(viol_irq)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called just after a negedge with the DUT idle; returns at the N+2 negedge.
  task automatic drive_req(input logic [63:0] a, input logic we, input logic [31:0] wd,
                           input logic [1:0] pr, input logic [3:0] ph,
                           output logic dn2, output logic rsp2, output logic err2, output logic early);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_priv = pr; req_periph = ph;
    @(negedge clk_i);
    req_valid = 1'b0;
    early = dn_valid | rsp_valid;
    @(negedge clk_i);
    dn2 = dn_valid; rsp2 = rsp_valid; err2 = rsp_err;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; acc_ctrl = '0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; req_priv = 2'b00; req_periph = '0; dn_ready = 1'b0; dn_rvalid = 1'b0;
    dn_rdata = '0; viol_clr = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %b exp 0", dn_valid); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b%b exp 00", rsp_valid, rsp_err); end
    checks++; if (viol_cnt !== 16'h0 || viol_irq !== 1'b0) begin errors++; $display("FAIL reset_log got %h/%b exp 0/0", viol_cnt, viol_irq); end
    checks++; if (dn_addr !== 64'h0) begin errors++; $display("FAIL reset_dn_addr got %h exp 0", dn_addr); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_allowed_read;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'h8}};
    drive_req(64'h1000, 1'b0, 32'h0, 2'b11, 4'd2, dn2, rsp2, err2, early);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL rd_check_quiet got %b exp 0", early); end
    checks++; if (dn2 !== 1'b1 || rsp2 !== 1'b0) begin errors++; $display("FAIL rd_dn_at_n2 got dn=%b rsp=%b exp dn=1 rsp=0", dn2, rsp2); end
    checks++; if (dn_addr !== 64'h1000 || dn_we !== 1'b0) begin errors++; $display("FAIL rd_dn_fields got %h/%b exp 1000/0", dn_addr, dn_we); end
    dn_ready = 1'b1;
    @(negedge clk_i);
    dn_ready = 1'b0;
    checks++; if (dn_valid !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait got dn=%b rsp=%b exp 0 0", dn_valid, rsp_valid); end
    dn_rvalid = 1'b1; dn_rdata = 32'hCAFEF00D;
    @(negedge clk_i);
    dn_rvalid = 1'b0; dn_rdata = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_resp got v=%b e=%b d=%h exp 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk_i);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_pulse got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_denied_write;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'h8}};
    drive_req(64'h4000_0010, 1'b1, 32'hDEAD, 2'b00, 4'd2, dn2, rsp2, err2, early);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL den_check_quiet got %b exp 0", early); end
    checks++; if (rsp2 !== 1'b1 || err2 !== 1'b1 || dn2 !== 1'b0) begin errors++; $display("FAIL den_err_at_n2 got v=%b e=%b dn=%b exp 1 1 0", rsp2, err2, dn2); end
    checks++; if (rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin errors++; $display("FAIL den_err_fields got d=%h rdy=%b exp 0 0", rsp_rdata, req_ready); end
    @(negedge clk_i);
    checks++; if (dn_valid !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL den_after got dn=%b rsp=%b exp 0 0", dn_valid, rsp_valid); end
    checks++; if (viol_cnt !== (LOG_EN ? 16'd1 : 16'd0) || viol_irq !== LOG_EN) begin errors++; $display("FAIL den_count got %h/%b exp %h/%b", viol_cnt, viol_irq, LOG_EN ? 16'd1 : 16'd0, LOG_EN); end
    checks++; if (viol_addr !== (LOG_EN ? 64'h4000_0010 : 64'h0) || viol_priv !== 2'b00) begin errors++; $display("FAIL den_capture got %h/%b", viol_addr, viol_priv); end
  endtask

  task automatic test_s_mode;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'h8}};
    acc_ctrl[15:12] = 4'h2;
    drive_req(64'h3000, 1'b0, 32'h0, 2'b01, 4'd3, dn2, rsp2, err2, early);
    checks++; if (dn2 !== 1'b1) begin errors++; $display("FAIL s_fwd got %b exp 1", dn2); end
    dn_ready = 1'b1; dn_rvalid = 1'b1; dn_rdata = 32'h1234_5678;
    @(negedge clk_i);
    dn_ready = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL s_direct_resp got v=%b d=%h exp 1 12345678", rsp_valid, rsp_rdata); end
    @(negedge clk_i);
    drive_req(64'h3004, 1'b0, 32'h0, 2'b01, 4'd4, dn2, rsp2, err2, early);
    checks++; if (err2 !== 1'b1 || dn2 !== 1'b0) begin errors++; $display("FAIL s_deny got e=%b dn=%b exp 1 0", err2, dn2); end
    @(negedge clk_i);
    checks++; if (viol_cnt !== (LOG_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL s_count got %h", viol_cnt); end
    checks++; if (viol_addr !== (LOG_EN ? 64'h4000_0010 : 64'h0)) begin errors++; $display("FAIL s_capture_held got %h", viol_addr); end
  endtask

  task automatic test_write_fwd;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'h8}};
    drive_req(64'h2000, 1'b1, 32'hA5A5_5A5A, 2'b11, 4'd0, dn2, rsp2, err2, early);
    checks++; if (dn2 !== 1'b1 || dn_we !== 1'b1 || dn_wdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL wr_fwd got dn=%b we=%b wd=%h", dn2, dn_we, dn_wdata); end
    dn_ready = 1'b1;
    @(negedge clk_i);
    dn_ready = 1'b0; dn_rvalid = 1'b1; dn_rdata = 32'hFFFF_FFFF;
    @(negedge clk_i);
    dn_rvalid = 1'b0; dn_rdata = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp got v=%b e=%b d=%h exp 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk_i);
  endtask

  task automatic test_always_denied;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'hF}};
    drive_req(64'h100, 1'b0, 32'h0, 2'b10, 4'd1, dn2, rsp2, err2, early);
    checks++; if (err2 !== 1'b1 || dn2 !== 1'b0) begin errors++; $display("FAIL priv10_deny got e=%b dn=%b exp 1 0", err2, dn2); end
    @(negedge clk_i);
    drive_req(64'h200, 1'b0, 32'h0, 2'b11, 4'd9, dn2, rsp2, err2, early);
    checks++; if (err2 !== 1'b1 || dn2 !== 1'b0) begin errors++; $display("FAIL periph_oor_deny got e=%b dn=%b exp 1 0", err2, dn2); end
    @(negedge clk_i);
    drive_req(64'h300, 1'b0, 32'h0, 2'b11, 4'd8, dn2, rsp2, err2, early);
    checks++; if (dn2 !== 1'b1) begin errors++; $display("FAIL periph_last_allow got %b exp 1", dn2); end
    dn_ready = 1'b1; dn_rvalid = 1'b1; dn_rdata = 32'h0BAD_CAFE;
    @(negedge clk_i);
    dn_ready = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL periph_last_resp got e=%b d=%h", rsp_err, rsp_rdata); end
    @(negedge clk_i);
    checks++; if (viol_cnt !== (LOG_EN ? 16'd4 : 16'd0)) begin errors++; $display("FAIL denied_count got %h", viol_cnt); end
  endtask

  task automatic test_perm_change;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'h8}};
    drive_req(64'h700, 1'b0, 32'h0, 2'b11, 4'd5, dn2, rsp2, err2, early);
    acc_ctrl = '0;
    @(negedge clk_i);
    checks++; if (dn2 !== 1'b1 || dn_valid !== 1'b1) begin errors++; $display("FAIL perm_change_hold got %b/%b exp 1/1", dn2, dn_valid); end
    dn_ready = 1'b1; dn_rvalid = 1'b1; dn_rdata = 32'h77;
    @(negedge clk_i);
    dn_ready = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h77) begin errors++; $display("FAIL perm_change_resp got v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk_i);
  endtask

  task automatic test_saturation;
    logic dn2, rsp2, err2, early;
    acc_ctrl = {9{4'h8}};
`ifdef ACCT_FILTER_LOG_EN
    force dut.viol_cnt_q = 16'hFFFE;
    @(negedge clk_i);
    release dut.viol_cnt_q;
`endif
    drive_req(64'h10, 1'b0, 32'h0, 2'b00, 4'd0, dn2, rsp2, err2, early);
    @(negedge clk_i);
    checks++; if (viol_cnt !== (LOG_EN ? 16'hFFFF : 16'h0)) begin errors++; $display("FAIL sat_first got %h", viol_cnt); end
    drive_req(64'h20, 1'b0, 32'h0, 2'b00, 4'd0, dn2, rsp2, err2, early);
    @(negedge clk_i);
    drive_req(64'h30, 1'b0, 32'h0, 2'b00, 4'd0, dn2, rsp2, err2, early);
    @(negedge clk_i);
    checks++; if (viol_cnt !== (LOG_EN ? 16'hFFFF : 16'h0)) begin errors++; $display("FAIL sat_hold got %h", viol_cnt); end
    checks++; if (viol_addr !== (LOG_EN ? 64'h4000_0010 : 64'h0)) begin errors++; $display("FAIL sat_capture_held got %h", viol_addr); end
    drive_req(64'h5555_0000, 1'b0, 32'h0, 2'b01, 4'd0, dn2, rsp2, err2, early);
    viol_clr = 1'b1;
    @(negedge clk_i);
    viol_clr = 1'b0;
    checks++; if (err2 !== 1'b1 || viol_cnt !== (LOG_EN ? 16'd1 : 16'd0) || viol_irq !== LOG_EN) begin errors++; $display("FAIL clr_with_err_count got e=%b cnt=%h irq=%b", err2, viol_cnt, viol_irq); end
    checks++; if (viol_addr !== (LOG_EN ? 64'h5555_0000 : 64'h0) || viol_priv !== (LOG_EN ? 2'b01 : 2'b00)) begin errors++; $display("FAIL clr_with_err_capture got %h/%b", viol_addr, viol_priv); end
    viol_clr = 1'b1;
    @(negedge clk_i);
    viol_clr = 1'b0;
    checks++; if (viol_cnt !== 16'h0 || viol_irq !== 1'b0 || viol_addr !== 64'h0) begin errors++; $display("FAIL clr_alone got cnt=%h irq=%b addr=%h exp 0", viol_cnt, viol_irq, viol_addr); end
  endtask

  task automatic test_reset_midtx;
    logic dn2, rsp2, err2, early;
    logic stable;
    acc_ctrl = {9{4'h8}};
    drive_req(64'h9000, 1'b0, 32'h0, 2'b11, 4'd2, dn2, rsp2, err2, early);
    stable = dn2;
    repeat (5) begin
      @(negedge clk_i);
      stable = stable & dn_valid & (dn_addr == 64'h9000);
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL fwd_stall_stable got %b exp 1", stable); end
    rst_ni = 1'b0;
    #1;
    checks++; if (dn_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || dn_addr !== 64'h0) begin errors++; $display("FAIL midtx_reset got dn=%b rdy=%b rsp=%b addr=%h", dn_valid, req_ready, rsp_valid, dn_addr); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midtx_dropped got rsp=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
    drive_req(64'h9100, 1'b0, 32'h0, 2'b11, 4'd2, dn2, rsp2, err2, early);
    checks++; if (dn2 !== 1'b1 || dn_addr !== 64'h9100) begin errors++; $display("FAIL post_reset_fwd got dn=%b addr=%h", dn2, dn_addr); end
    dn_ready = 1'b1; dn_rvalid = 1'b1; dn_rdata = 32'h600D_F00D;
    @(negedge clk_i);
    dn_ready = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h600D_F00D) begin errors++; $display("FAIL post_reset_resp got v=%b d=%h", rsp_valid, rsp_rdata); end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_allowed_read();
    test_denied_write();
    test_s_mode();
    test_write_fwd();
    test_always_denied();
    test_perm_change();
    test_saturation();
    test_reset_midtx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
